// File: rtl/fetch_unit.sv
// Purpose : instruction fetch unit; word-aligned PC, one-cycle memory, DEPTH-entry in-order queue.
// Latency : start edge k -> request in cycle k+1 -> instr_valid_o after edge k+2; one instruction per cycle sustained.
// Backpressure: requests stop while queue occupancy plus in-flight reaches DEPTH; memory is never stalled.
//
// Ports:
//   clk_i, rst_i (async, active-high)      clock and reset
//   start_i                                level; 1 = fetch enabled
//   imem_req_o / imem_addr_o               fetch request and its word address
//   imem_rvalid_i / imem_rdata_i           response, exactly one cycle after the request
//   redirect_i / redirect_pc_i             redirect pulse and target (bits [1:0] ignored)
//   instr_valid_o / instr_o / instr_pc_o   queue head
//   instr_ready_i                          consumer accepts the head
//   fetch_cnt_o / stall_cnt_o              saturating counters, only with FETCH_PERF_CNT_EN defined
//
// Optional feature macro: FETCH_PERF_CNT_EN

module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_rvalid_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              instr_valid_o,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    input  logic              instr_ready_i
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       stall_cnt_o
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] pc;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_pc;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic [CNT_W-1:0]  occupancy;
    logic              push;
    logic              pop;

    // Low target bits are architecturally ignored.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // Credits count the outstanding response too, so a full queue never has to refuse one.
    assign occupancy     = count + CNT_W'(inflight_q);
    assign imem_req_o    = (state == ST_RUN) && !redirect_i && (occupancy < CNT_W'(DEPTH));
    assign imem_addr_o   = pc;

    // A response that coincides with a redirect belongs to the abandoned path; inflight_q
    // also filters any response that has no issued request behind it (e.g. after reset).
    assign push          = imem_rvalid_i && inflight_q && !redirect_i;
    assign instr_valid_o = (count != '0) && !redirect_i;
    assign pop           = instr_valid_o && instr_ready_i;

    // Head comes straight from storage; storage is cleared on reset so the head reads 0.
    assign instr_o       = data_mem[rd_ptr];
    assign instr_pc_o    = pc_mem[rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            inflight_q  <= 1'b0;
            inflight_pc <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start_i)  state <= ST_RUN;
                ST_RUN:  if (!start_i) state <= ST_IDLE;
                default:               state <= ST_IDLE;
            endcase

            // Requests are never issued in a redirect cycle, so a redirect also clears this.
            inflight_q <= imem_req_o;
            if (imem_req_o) begin
                inflight_pc <= pc;
            end

            if (redirect_i) begin
                pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
            end else if (imem_req_o) begin
                pc <= pc + ADDR_W'(4);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (redirect_i) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= imem_rdata_i;
                pc_mem[wr_ptr]   <= inflight_pc;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (push && (fetch_cnt_o != 32'hFFFF_FFFF)) begin
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            end
            if ((state == ST_RUN) && !imem_req_o && !redirect_i &&
                (stall_cnt_o != 32'hFFFF_FFFF)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose : self-checking bench for fetch_unit; table of per-cycle vectors plus hand sequences.
// Latency : memory model answers exactly one cycle after each request, data = addr ^ 0xA5A5A5A5.
// Backpressure: consumer ready driven per vector; bench never stalls the memory model.

module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        req;
    logic [31:0] addr;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        ivalid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        ready;

    logic        s_start;
    logic        s_req;
    logic [7:0]  s_addr;
    logic        s_rvalid;
    logic [31:0] s_rdata;
    logic        s_redir;
    logic [7:0]  s_rpc;
    logic        s_valid;
    logic [31:0] s_instr;
    logic [7:0]  s_ipc;
    logic        s_ready;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] s_fetch_cnt;
    logic [31:0] s_stall_cnt;
`endif

    fetch_unit dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_rvalid_i (m_rvalid),
        .imem_rdata_i  (m_rdata),
        .redirect_i    (redir),
        .redirect_pc_i (rpc),
        .instr_valid_o (ivalid),
        .instr_o       (instr),
        .instr_pc_o    (ipc),
        .instr_ready_i (ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o   (fetch_cnt),
        .stall_cnt_o   (stall_cnt)
`endif
    );

    fetch_unit #(
        .ADDR_W   (8),
        .DATA_W   (32),
        .DEPTH    (4),
        .RESET_PC (8'hF8)
    ) dut_small (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (s_start),
        .imem_req_o    (s_req),
        .imem_addr_o   (s_addr),
        .imem_rvalid_i (s_rvalid),
        .imem_rdata_i  (s_rdata),
        .redirect_i    (s_redir),
        .redirect_pc_i (s_rpc),
        .instr_valid_o (s_valid),
        .instr_o       (s_instr),
        .instr_pc_o    (s_ipc),
        .instr_ready_i (s_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o   (s_fetch_cnt),
        .stall_cnt_o   (s_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: respond one cycle after each request; not reset, so a late response
    // can still appear right after a reset pulse.
    initial begin
        m_rvalid = 1'b0;
        m_rdata  = '0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
    end
    always @(posedge clk) begin
        m_rvalid <= req;
        m_rdata  <= addr ^ 32'hA5A5_A5A5;
        s_rvalid <= s_req;
        s_rdata  <= {24'h0, s_addr} ^ 32'hA5A5_A5A5;
    end

    int total;
    int passed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          rst_before;
        bit          start;
        bit          ready;
        bit          redir;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t v(input bit r, input bit s, input bit rd, input bit rr,
                               input logic [31:0] rp, input bit eq, input logic [31:0] ea,
                               input bit ev, input logic [31:0] ep);
        vec_t t;
        t.rst_before = r;
        t.start      = s;
        t.ready      = rd;
        t.redir      = rr;
        t.rpc        = rp;
        t.e_req      = eq;
        t.e_addr     = ea;
        t.e_valid    = ev;
        t.e_pc       = ep;
        return t;
    endfunction

    // Ends on a negedge with reset released; the next row runs in the first post-reset cycle.
    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        start   = 1'b0;
        ready   = 1'b0;
        redir   = 1'b0;
        rpc     = '0;
        s_start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tbl[$];

    initial begin
        total   = 0;
        passed  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        ready   = 1'b0;
        redir   = 1'b0;
        rpc     = '0;
        s_start = 1'b0;
        s_redir = 1'b0;
        s_rpc   = '0;
        s_ready = 1'b1;

        // Stream from reset, consumer always ready.
        tbl.push_back(v(1, 1, 1, 0, 0, 0, 32'h00, 0, 32'h00));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h00, 0, 32'h00));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h04, 0, 32'h00));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h08, 1, 32'h00));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h0C, 1, 32'h04));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h10, 1, 32'h08));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h14, 1, 32'h0C));
        // Consumer stalled: exactly four requests, then release.
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 32'h00, 0, 32'h00));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 32'h00, 0, 32'h00));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 32'h04, 0, 32'h00));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 32'h08, 1, 32'h00));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 32'h0C, 1, 32'h00));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h10, 1, 32'h00));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h10, 1, 32'h00));
        tbl.push_back(v(0, 1, 1, 0, 0, 0, 32'h10, 1, 32'h00));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h10, 1, 32'h04));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h14, 1, 32'h08));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h18, 1, 32'h0C));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h1C, 1, 32'h10));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h20, 1, 32'h14));
        // Redirect to 0x103 with two queued and one response arriving.
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 32'h00, 0, 32'h00));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 32'h00, 0, 32'h00));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 32'h04, 0, 32'h00));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 32'h08, 1, 32'h00));
        tbl.push_back(v(0, 1, 1, 1, 32'h103, 0, 32'h00, 0, 32'h00));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h100, 0, 32'h00));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h104, 0, 32'h00));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h108, 1, 32'h100));
        // start_i dropped with one request in flight, then restart.
        tbl.push_back(v(1, 1, 1, 0, 0, 0, 32'h00, 0, 32'h00));
        tbl.push_back(v(0, 0, 1, 0, 0, 1, 32'h00, 0, 32'h00));
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 32'h00, 0, 32'h00));
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 32'h00, 1, 32'h00));
        tbl.push_back(v(0, 1, 1, 0, 0, 0, 32'h00, 0, 32'h00));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h04, 0, 32'h00));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h08, 0, 32'h00));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h0C, 1, 32'h04));

        // Outputs held at zero while reset is asserted.
        #3;
        chk("reset req",       {31'h0, req},    32'h0);
        chk("reset valid",     {31'h0, ivalid}, 32'h0);
        chk("reset instr",     instr,           32'h0);
        chk("reset instr_pc",  ipc,             32'h0);
        chk("reset addr",      addr,            32'h0);
        chk("reset small req", {31'h0, s_req},  32'h0);
        chk("reset small pc",  {24'h0, s_addr}, 32'h0000_00F8);

        foreach (tbl[i]) begin
            if (tbl[i].rst_before) begin
                do_reset();
            end else begin
                @(negedge clk);
            end
            start = tbl[i].start;
            ready = tbl[i].ready;
            redir = tbl[i].redir;
            rpc   = tbl[i].rpc;
            #1;
            chk($sformatf("row%0d req", i), {31'h0, req}, {31'h0, tbl[i].e_req});
            if (tbl[i].e_req) begin
                chk($sformatf("row%0d addr", i), addr, tbl[i].e_addr);
            end
            chk($sformatf("row%0d valid", i), {31'h0, ivalid}, {31'h0, tbl[i].e_valid});
            if (tbl[i].e_valid) begin
                chk($sformatf("row%0d instr_pc", i), ipc, tbl[i].e_pc);
                chk($sformatf("row%0d instr", i), instr, tbl[i].e_pc ^ 32'hA5A5_A5A5);
            end
        end

`ifdef FETCH_PERF_CNT_EN
        // Last table rows: two entries pushed and delivered, no stall cycles in RUN.
        chk("perf fetch after restart", fetch_cnt, 32'd2);
        chk("perf stall after restart", stall_cnt, 32'd0);
        do_reset();
        start = 1'b1;
        ready = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk("perf fetch full queue", fetch_cnt, 32'd4);
        chk("perf stall full queue", stall_cnt, 32'd3);
`endif

        // Async reset between edges with one queued entry and a response on the bus.
        do_reset();
        start = 1'b1;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre-rst valid", {31'h0, ivalid}, 32'h1);
        chk("pre-rst addr",  addr,            32'h8);
        rst = 1'b1;
        #1;
        chk("async rst req",      {31'h0, req},    32'h0);
        chk("async rst valid",    {31'h0, ivalid}, 32'h0);
        chk("async rst instr",    instr,           32'h0);
        chk("async rst instr_pc", ipc,             32'h0);
        chk("async rst addr",     addr,            32'h0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("late rvalid ignored", {31'h0, ivalid}, 32'h0);
        chk("restart req",         {31'h0, req},    32'h1);
        chk("restart addr",        addr,            32'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("restart head pc",    ipc,   32'h0);
        chk("restart head instr", instr, 32'hA5A5_A5A5);

        // Narrow address: PC wraps from 0xFC to 0x00.
        do_reset();
        s_start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] exp_a;
            exp_a = 8'hF8 + 8'(4 * k);
            @(negedge clk);
            #1;
            chk($sformatf("wrap req%0d", k),  {31'h0, s_req},  32'h1);
            chk($sformatf("wrap addr%0d", k), {24'h0, s_addr}, {24'h0, exp_a});
        end
        s_start = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
